// File: rtl/bias_acc_ctrl_pkg.sv
// bias_acc_ctrl_pkg: shared FSM encodings, adder latency default and tag record layout.
`ifndef IMG_DATA_W
`define IMG_DATA_W 8
`endif
package bias_acc_ctrl_pkg;
  localparam int IMG_DW = `IMG_DATA_W;
  localparam int ACC_LAT_DEF = 2;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
  // tag record {ch, last_pix, last_ch}; the valid bit travels alongside it
  localparam int TAG_LC = 0;
  localparam int TAG_LP = 1;
  localparam int TAG_CH = 2;
  function automatic int tag_w(input int ch_w);
    return ch_w + TAG_CH;
  endfunction
endpackage

// File: rtl/bias_acc_ctrl_if.sv
// bias_acc_ctrl_if: partial-sum, accumulator and result signals of the bias-add stage.
interface bias_acc_ctrl_if #(
  parameter int DATA_W = bias_acc_ctrl_pkg::IMG_DW,
  parameter int NUM_CH = 16
);
  logic                      ps_valid;
  logic                      ps_ready;
  logic [2*DATA_W-1:0]       ps_data;
  logic                      acc_ena;
  logic [2*DATA_W-1:0]       acc_data;
  logic [DATA_W-1:0]         acc_bias;
  logic [DATA_W-1:0]         acc_out;
  logic                      res_valid;
  logic [DATA_W-1:0]         res_data;
  logic [$clog2(NUM_CH)-1:0] res_ch;
  logic                      ch_done;
  logic                      layer_done;
  modport master (
    input  ps_valid, ps_data, acc_out,
    output ps_ready, acc_ena, acc_data, acc_bias, res_valid, res_data, res_ch, ch_done, layer_done
  );
  modport slave (
    output ps_valid, ps_data, acc_out,
    input  ps_ready, acc_ena, acc_data, acc_bias, res_valid, res_data, res_ch, ch_done, layer_done
  );
endinterface

// File: rtl/bias_acc_ctrl_tag.sv
// bias_tag_pipe: ACC_LAT-deep valid/tag shift register with an empty flag.
module bias_tag_pipe
  import bias_acc_ctrl_pkg::*;
#(
  parameter int ACC_LAT = ACC_LAT_DEF,
  parameter int W       = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         v_i,
  input  logic [W-1:0] tag_i,
  output logic         v_o,
  output logic [W-1:0] tag_o,
  output logic         empty_o
);
  logic [ACC_LAT-1:0]        v_q;
  logic [ACC_LAT-1:0][W-1:0] t_q;
  logic [ACC_LAT:0]          v_in;
  logic [ACC_LAT:0][W-1:0]   t_in;
  assign v_in = {v_q, v_i};
  assign t_in = {t_q, tag_i};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      t_q <= '0;
    end else begin
      v_q <= v_in[ACC_LAT-1:0];
      t_q <= t_in[ACC_LAT-1:0];
    end
  assign v_o     = v_q[ACC_LAT-1];
  assign tag_o   = t_q[ACC_LAT-1];
  assign empty_o = ~|v_q;
endmodule

// File: rtl/bias_acc_ctrl.sv
// bias_acc_ctrl: sequences bias-add accumulation per channel/pixel and tags results.
// Optional BIAS_ACC_CTRL_RELU_EN clamps negative results to zero.
module bias_acc_ctrl
  import bias_acc_ctrl_pkg::*;
#(
  parameter int DATA_W  = IMG_DW,
  parameter int NUM_CH  = 16,
  parameter int PIX_W   = 16,
  parameter int ACC_LAT = ACC_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bias_we,
  input  logic [$clog2(NUM_CH)-1:0]   bias_addr,
  input  logic [DATA_W-1:0]           bias_wdata,
  input  logic                        start,
  input  logic [$clog2(NUM_CH):0]     cfg_num_ch,
  input  logic [PIX_W-1:0]            cfg_num_pix,
  output logic                        busy,
  bias_acc_ctrl_if.master             bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int TW   = tag_w(CH_W);
  state_e                        state_q;
  logic [CH_W:0]                 num_ch_q;
  logic [PIX_W-1:0]              num_pix_q, pix_q, pix_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [NUM_CH-1:0][DATA_W-1:0] bias_q;
  logic                          ena_q, zdone_q;
  logic [2*DATA_W-1:0]           data_q;
  logic [DATA_W-1:0]             abias_q;
  logic [TW-1:0]                 tag_q, pipe_tag;
  logic                          xfer, last_pix, last_ch, pipe_v, pipe_empty;
  assign xfer     = bus.ps_valid && state_q == S_RUN;
  assign last_pix = pix_q == num_pix_q - PIX_W'(1);
  assign last_ch  = {1'b0, ch_q} == num_ch_q - (CH_W+1)'(1);
  always_comb begin
    pix_d = last_pix ? '0 : pix_q + PIX_W'(1);
    ch_d  = last_pix ? ch_q + CH_W'(1) : ch_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      num_ch_q  <= '0;
      num_pix_q <= '0;
      pix_q     <= '0;
      ch_q      <= '0;
      bias_q    <= '0;
      ena_q     <= 1'b0;
      zdone_q   <= 1'b0;
      data_q    <= '0;
      abias_q   <= '0;
      tag_q     <= '0;
    end else begin
      ena_q   <= xfer;
      zdone_q <= state_q == S_DONE && (num_ch_q == '0 || num_pix_q == '0);
      if (xfer) begin
        data_q  <= bus.ps_data;
        abias_q <= bias_q[ch_q];
        tag_q   <= {ch_q, last_pix, last_ch};
        pix_q   <= pix_d;
        ch_q    <= ch_d;
      end
      case (state_q)
        S_IDLE: begin
          if (bias_we) bias_q[bias_addr] <= bias_wdata;
          if (start) begin
            num_ch_q  <= cfg_num_ch;
            num_pix_q <= cfg_num_pix;
            ch_q      <= '0;
            pix_q     <= '0;
            state_q   <= (cfg_num_ch == '0 || cfg_num_pix == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN:   if (xfer && last_pix && last_ch) state_q <= S_DRAIN;
        // the acc_ena stage still holds the final item for one cycle after RUN ends
        S_DRAIN: if (pipe_empty && !ena_q) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  bias_tag_pipe #(.ACC_LAT(ACC_LAT), .W(TW)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .v_i     (ena_q),
    .tag_i   (tag_q),
    .v_o     (pipe_v),
    .tag_o   (pipe_tag),
    .empty_o (pipe_empty)
  );
  assign busy           = state_q != S_IDLE;
  assign bus.ps_ready   = state_q == S_RUN;
  assign bus.acc_ena    = ena_q;
  assign bus.acc_data   = data_q;
  assign bus.acc_bias   = abias_q;
  assign bus.res_valid  = pipe_v;
  assign bus.res_ch     = pipe_tag[TW-1:TAG_CH];
  assign bus.ch_done    = pipe_v & pipe_tag[TAG_LP];
  assign bus.layer_done = (pipe_v & pipe_tag[TAG_LP] & pipe_tag[TAG_LC]) | zdone_q;
`ifdef BIAS_ACC_CTRL_RELU_EN
  assign bus.res_data = bus.acc_out[DATA_W-1] ? '0 : bus.acc_out;
`else
  assign bus.res_data = bus.acc_out;
`endif
endmodule

// File: tb/tb_bias_acc_ctrl.sv
// tb_bias_acc_ctrl: randomized scenarios checked against a per-layer result list model.
`timescale 1ns/1ps
module tb_bias_acc_ctrl;
  localparam int DW = 8, NCH = 16, PW = 16;
  logic clk = 1'b0, rst_n = 1'b0, bias_we = 1'b0, start = 1'b0, busy;
  logic [3:0] bias_addr = '0;
  logic [DW-1:0] bias_wdata = '0;
  logic [4:0] cfg_num_ch = '0;
  logic [PW-1:0] cfg_num_pix = '0;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [DW-1:0] mbias [NCH];
  logic [DW-1:0] acc_s1, acc_s2, frc_val = '0;
  logic frc_en = 1'b0;
  bias_acc_ctrl_if #(.DATA_W(DW), .NUM_CH(NCH)) bus ();
  bias_acc_ctrl #(.DATA_W(DW), .NUM_CH(NCH), .PIX_W(PW), .ACC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .start(start), .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix), .busy(busy), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // external accumulator: two-cycle truncating adder
  always @(posedge clk) begin
    acc_s1 <= bus.acc_data[DW-1:0] + bus.acc_bias;
    acc_s2 <= acc_s1;
  end
  assign bus.acc_out = frc_en ? frc_val : acc_s2;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef BIAS_ACC_CTRL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic write_bias(input int a, input logic [DW-1:0] v);
    bias_we = 1'b1; bias_addr = 4'(a); bias_wdata = v;
    @(posedge clk); #1;
    bias_we = 1'b0;
    mbias[a] = v;
  endtask

  task automatic run_layer(input int nch, input int npix, input int gap, input bit poke, input bit wstart);
    int total;
    logic [2*DW-1:0] psd [$];
    logic [DW-1:0] eb [$], er [$];
    logic [3:0] ec [$];
    bit ecd [$], eld [$];
    int xt [$];
    int iss, res, tail;
    bit prev_x;
    logic [2*DW-1:0] d;
    logic [DW-1:0] s;
    total = nch * npix; iss = 0; res = 0; tail = 0; prev_x = 0;
    if (wstart) begin bias_we = 1'b1; bias_addr = '0; bias_wdata = DW'($urandom); mbias[0] = bias_wdata; end
    start = 1'b1; cfg_num_ch = 5'(nch); cfg_num_pix = PW'(npix);
    for (int c = 0; c < nch; c++)
      for (int p = 0; p < npix; p++) begin
        d = (2*DW)'($urandom);
        s = d[DW-1:0] + mbias[c];
        psd.push_back(d); eb.push_back(mbias[c]); er.push_back(relu(s)); ec.push_back(4'(c));
        ecd.push_back(p == npix - 1); eld.push_back(p == npix - 1 && c == nch - 1);
      end
    @(posedge clk); #1;
    start = 1'b0; bias_we = 1'b0;
    fork
      begin
        for (int k = 0; k < total; k++) begin
          for (int g = 0; g < 20 && $urandom_range(99) < gap; g++) begin
            bus.ps_valid = 1'b0; @(posedge clk); #1;
          end
          if (poke && k == total / 2) begin
            bias_we = 1'b1; bias_addr = '0; bias_wdata = ~mbias[0];
            start = 1'b1; cfg_num_ch = 5'd1; cfg_num_pix = 16'd1;
          end
          bus.ps_valid = 1'b1; bus.ps_data = psd[k];
          for (int w = 0; w < 50; w++) begin @(negedge clk); if (bus.ps_ready) break; end
          @(posedge clk); #1;
          bias_we = 1'b0; start = 1'b0;
        end
        bus.ps_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 4000 && tail < 6; n++) begin
          @(negedge clk);
          vectors++;
          if (bus.acc_ena !== prev_x) begin
            miscompares++;
            $display("FAIL acc_ena cyc %0d got %b want %b", cyc, bus.acc_ena, prev_x);
          end else if (prev_x && iss < total) begin
            vectors++;
            if (bus.acc_data !== psd[iss] || bus.acc_bias !== eb[iss]) begin
              miscompares++;
              $display("FAIL acc_issue #%0d got data %h bias %h want data %h bias %h", iss, bus.acc_data, bus.acc_bias, psd[iss], eb[iss]);
            end
            iss++;
          end
          prev_x = bus.ps_valid && bus.ps_ready;
          if (prev_x) xt.push_back(cyc);
          vectors++;
          if (bus.res_valid) begin
            if (res >= total) begin
              miscompares++;
              $display("FAIL extra_result cyc %0d got res_valid 1 want 0", cyc);
            end else begin
              if (bus.res_ch !== ec[res] || bus.res_data !== er[res] || bus.ch_done !== ecd[res] ||
                  bus.layer_done !== eld[res] || (res < xt.size() ? cyc - xt[res] : -1) != 3) begin
                miscompares++;
                $display("FAIL result #%0d got ch %0d data %h chd %b lyd %b lat %0d want ch %0d data %h chd %b lyd %b lat 3",
                         res, bus.res_ch, bus.res_data, bus.ch_done, bus.layer_done,
                         res < xt.size() ? cyc - xt[res] : -1, ec[res], er[res], ecd[res], eld[res]);
              end
              res++;
            end
          end else if (bus.ch_done !== 1'b0 || bus.layer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done cyc %0d got chd %b lyd %b want 0 0", cyc, bus.ch_done, bus.layer_done);
          end
          if (res == total) tail++;
        end
        vectors++;
        if (res != total || iss != total) begin
          miscompares++;
          $display("FAIL layer_timeout got %0d results %0d issues want %0d", res, iss, total);
        end
        vectors++;
        if (busy !== 1'b0 || bus.ps_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL layer_end got busy %b ready %b want 0 0", busy, bus.ps_ready);
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    vectors++;
    if ({bus.ps_ready, bus.acc_ena, bus.res_valid, bus.ch_done, bus.layer_done, busy} !== 6'b0 ||
        bus.acc_data !== '0 || bus.acc_bias !== '0 || bus.res_ch !== '0) begin
      miscompares++;
      $display("FAIL reset_init got flags %b data %h bias %h ch %h want all 0",
               {bus.ps_ready, bus.acc_ena, bus.res_valid, bus.ch_done, bus.layer_done, busy},
               bus.acc_data, bus.acc_bias, bus.res_ch);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    write_bias(0, 8'h7F);
    start = 1'b1; cfg_num_ch = 5'd2; cfg_num_pix = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; bus.ps_valid = 1'b1;
    repeat (3) begin bus.ps_data = 16'($urandom) | 16'h0101; @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ps_ready, bus.acc_ena, bus.res_valid, bus.ch_done, bus.layer_done, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_flags got %b want 000000",
               {bus.ps_ready, bus.acc_ena, bus.res_valid, bus.ch_done, bus.layer_done, busy});
    end
    vectors++;
    if (bus.acc_data !== '0 || bus.acc_bias !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_data got data %h bias %h want 0 0", bus.acc_data, bus.acc_bias);
    end
    bus.ps_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.layer_done !== 1'b0 || bus.res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold got lyd %b rv %b want 0 0", bus.layer_done, bus.res_valid);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) mbias[i] = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    write_bias(0, 8'd3);
    write_bias(1, 8'hFE);
    run_layer(2, 3, 0, 0, 0);
  endtask

  task automatic test_gaps;
    for (int i = 0; i < NCH; i++) write_bias(i, DW'($urandom));
    run_layer(3, 5, 40, 0, 0);
    run_layer(2, 7, 60, 0, 0);
  endtask

  task automatic test_ignored;
    run_layer(2, 4, 20, 1, 0);
    run_layer(1, 3, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_layer(NCH, 2, 0, 0, 0);
    run_layer(1, 1, 0, 0, 1);
    run_layer(4, 1, 0, 0, 1);
  endtask

  task automatic test_zero_cfg;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; cfg_num_ch = t == 0 ? 5'd3 : 5'd0; cfg_num_pix = t == 0 ? 16'd0 : 16'd5;
      bus.ps_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        vectors++;
        if (bus.layer_done !== (i == 2) || bus.acc_ena !== 1'b0 || bus.ch_done !== 1'b0 || busy !== (i == 1)) begin
          miscompares++;
          $display("FAIL zero_cfg%0d step %0d got lyd %b ena %b chd %b busy %b want lyd %b ena 0 chd 0 busy %b",
                   t, i, bus.layer_done, bus.acc_ena, bus.ch_done, busy, i == 2, i == 1);
        end
      end
      @(posedge clk); #1;
      bus.ps_valid = 1'b0;
    end
  endtask

  task automatic test_relu;
    logic [DW-1:0] vals [3];
    vals[0] = 8'hF0; vals[1] = 8'h05; vals[2] = 8'h80;
    frc_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frc_val = vals[i];
      #1;
      vectors++;
      if (bus.res_data !== relu(vals[i])) begin
        miscompares++;
        $display("FAIL relu acc_out %h got %h want %h", vals[i], bus.res_data, relu(vals[i]));
      end
    end
    frc_en = 1'b0;
  endtask

  initial begin
    bus.ps_valid = 1'b0;
    bus.ps_data = '0;
    for (int i = 0; i < NCH; i++) mbias[i] = '0;
    test_reset;
    test_basic;
    test_gaps;
    test_ignored;
    test_back_to_back;
    test_zero_cfg;
    test_relu;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
